// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage of the 5-stage pipeline.
// Owns the PC, drives the instruction memory request and produces the
// IF/ID register (instruction, PC, PC+2, halt flag) consumed by decode.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stallCtrl                     hazard stall: hold PC and IF/ID
//   takeBranch_EXMEM/branchTarget branch redirect (highest priority after rst)
//   jumpFlush/jumpTarget          jump redirect from decode
//   imem_addr/imem_rd             instruction memory request
//   imem_data/imem_stall/imem_done instruction memory response
//   instr_IFID/PC_IFID/PC2_IFID/halt_IFID  IF/ID pipeline register
//   err                           sticky misaligned-redirect error
//
// Build option: FETCH_ALIGN_CHECK_EN
//   defined   - odd redirect target sets err and halts fetch
//   undefined - target bit 0 is cleared, err tied low
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallCtrl,
  input  logic        takeBranch_EXMEM,
  input  logic [15:0] branchTarget,
  input  logic        jumpFlush,
  input  logic [15:0] jumpTarget,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_stall,
  input  logic        imem_done,
  output logic [15:0] instr_IFID,
  output logic [15:0] PC_IFID,
  output logic [15:0] PC2_IFID,
  output logic        halt_IFID,
  output logic        err
);

  typedef enum logic [1:0] {RUN, WAIT, HALTED} state_t;

  state_t      state;
  logic [15:0] pc;
  logic        squash;
  logic [15:0] sq_addr;
  logic        hold_valid;
  logic [15:0] hold_word;

  logic        redirect;
  logic [15:0] target;
  logic [15:0] fetch_target;
  logic        misaligned;
  logic        word_valid;
  logic [15:0] word;
  logic        is_halt;

  always_comb begin
    redirect   = takeBranch_EXMEM | jumpFlush;
    target     = takeBranch_EXMEM ? branchTarget : jumpTarget;
`ifdef FETCH_ALIGN_CHECK_EN
    misaligned   = target[0];
    fetch_target = target;
`else
    misaligned   = 1'b0;
    fetch_target = target & 16'hFFFE;
`endif
    // A completion while squashing belongs to the cancelled request.
    word_valid = hold_valid | (imem_done & imem_rd & ~squash);
    word       = hold_valid ? hold_word : imem_data;
    is_halt    = (word[15:11] == 5'b00000);
  end

  // The old address is kept on the bus until the cancelled request drains;
  // once a word is buffered during a stall the request is dropped.
  assign imem_rd   = squash | ((state != HALTED) & ~hold_valid);
  assign imem_addr = squash ? sq_addr : pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (redirect && misaligned)
      err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      instr_IFID <= NOP_INSTR;
      PC_IFID    <= '0;
      PC2_IFID   <= '0;
      halt_IFID  <= 1'b0;
      squash     <= 1'b0;
      sq_addr    <= '0;
      hold_valid <= 1'b0;
      hold_word  <= '0;
    end else if (redirect) begin
      hold_valid <= 1'b0;
      // Request still outstanding: remember it so its completion is dropped.
      if (imem_rd && !imem_done) begin
        squash <= 1'b1;
        if (!squash)
          sq_addr <= pc;
      end else begin
        squash <= 1'b0;
      end
      instr_IFID <= NOP_INSTR;
      pc         <= fetch_target;
      if (misaligned) begin
        state     <= HALTED;
        halt_IFID <= 1'b1;
      end else begin
        state     <= RUN;
        halt_IFID <= 1'b0;
      end
    end else if (stallCtrl) begin
      if (squash && imem_done)
        squash <= 1'b0;
      if (word_valid && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_word  <= imem_data;
      end
    end else if (squash) begin
      if (imem_done)
        squash <= 1'b0;
      if (state != HALTED) begin
        instr_IFID <= NOP_INSTR;
        halt_IFID  <= 1'b0;
      end
    end else if (state != HALTED) begin
      if (word_valid) begin
        hold_valid <= 1'b0;
        instr_IFID <= word;
        PC_IFID    <= pc;
        PC2_IFID   <= pc + 16'd2;
        halt_IFID  <= is_halt;
        if (is_halt) begin
          state <= HALTED;
        end else begin
          pc    <= pc + 16'd2;
          state <= RUN;
        end
      end else begin
        instr_IFID <= NOP_INSTR;
        halt_IFID  <= 1'b0;
        state      <= imem_stall ? WAIT : RUN;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallCtrl;
  logic        takeBranch_EXMEM;
  logic [15:0] branchTarget;
  logic        jumpFlush;
  logic [15:0] jumpTarget;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic        imem_stall;
  logic        imem_done;
  logic [15:0] instr_IFID;
  logic [15:0] PC_IFID;
  logic [15:0] PC2_IFID;
  logic        halt_IFID;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst(rst), .stallCtrl(stallCtrl),
    .takeBranch_EXMEM(takeBranch_EXMEM), .branchTarget(branchTarget),
    .jumpFlush(jumpFlush), .jumpTarget(jumpTarget),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .imem_stall(imem_stall), .imem_done(imem_done),
    .instr_IFID(instr_IFID), .PC_IFID(PC_IFID), .PC2_IFID(PC2_IFID),
    .halt_IFID(halt_IFID), .err(err)
  );

  // Memory model: one address may be given extra latency (wait_n cycles).
  logic [15:0] wait_addr;
  logic [3:0]  wait_n;
  logic [3:0]  busy_cnt;
  logic [3:0]  mem_need;
  int          rd6_count;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (a < 16'h000A)      return 16'h4001 + {1'b0, a[15:1]};
    else if (a == 16'h000A) return 16'h0000;
    else                   return 16'h8000 | a;
  endfunction

  always_comb begin
    mem_need   = (imem_addr == wait_addr) ? wait_n : 4'd0;
    imem_done  = imem_rd && (busy_cnt >= mem_need);
    imem_stall = imem_rd && !imem_done;
    imem_data  = imem_done ? word_at(imem_addr) : 16'h0000;
  end

  always @(posedge clk) begin
    if (rst) begin
      busy_cnt  <= 4'd0;
      rd6_count <= 0;
    end else begin
      busy_cnt <= (imem_rd && !imem_done) ? busy_cnt + 4'd1 : 4'd0;
      if (imem_done && imem_addr == 16'h0006)
        rd6_count <= rd6_count + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stallCtrl = 1'b0;
    takeBranch_EXMEM = 1'b0; branchTarget = '0;
    jumpFlush = 1'b0; jumpTarget = '0;
    wait_addr = 16'hFFFF; wait_n = 4'd0;

    // Reset values and single-cycle memory
    tick(); tick();
    check("rst_instr", instr_IFID, 16'h0800);
    check("rst_pc", PC_IFID, 16'h0000);
    check("rst_pc2", PC2_IFID, 16'h0000);
    check("rst_halt", {15'd0, halt_IFID}, 16'd0);
    check("rst_err", {15'd0, err}, 16'd0);
    rst = 1'b0;
    check("rd_after_rst", {15'd0, imem_rd}, 16'd1);
    check("addr_after_rst", imem_addr, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seq_instr", instr_IFID, 16'h4001 + 16'(i));
      check("seq_pc", PC_IFID, 16'(2 * i));
      check("seq_pc2", PC2_IFID, 16'(2 * i + 2));
    end

    // Two-cycle memory wait at 0x0004
    wait_addr = 16'h0004; wait_n = 4'd2;
    do_reset();
    tick(); tick();
    check("wait_addr0", imem_addr, 16'h0004);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("wait_bubble", instr_IFID, 16'h0800);
      check("wait_addr", imem_addr, 16'h0004);
    end
    tick();
    check("wait_instr", instr_IFID, 16'h4003);
    check("wait_pc", PC_IFID, 16'h0004);

    // Hazard stall while 0x0006 completes
    wait_addr = 16'hFFFF;
    stallCtrl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_frozen", instr_IFID, 16'h4003);
    end
    check("stall_rd_off", {15'd0, imem_rd}, 16'd0);
    stallCtrl = 1'b0;
    tick();
    check("stall_release_instr", instr_IFID, 16'h4004);
    check("stall_release_pc", PC_IFID, 16'h0006);
    check("stall_single_read", 16'(rd6_count), 16'd1);
    check("stall_next_addr", imem_addr, 16'h0008);

    // Simultaneous branch and jump: branch wins
    takeBranch_EXMEM = 1'b1; branchTarget = 16'h0040;
    jumpFlush = 1'b1; jumpTarget = 16'h0080;
    tick();
    takeBranch_EXMEM = 1'b0; jumpFlush = 1'b0;
    check("redir_addr", imem_addr, 16'h0040);
    check("redir_nop", instr_IFID, 16'h0800);
    tick();
    check("redir_instr", instr_IFID, 16'h8040);
    check("redir_pc", PC_IFID, 16'h0040);

    // HALT at 0x000A, then branch out of HALTED
    jumpFlush = 1'b1; jumpTarget = 16'h0008;
    tick();
    jumpFlush = 1'b0;
    tick();
    check("pre_halt_instr", instr_IFID, 16'h4005);
    tick();
    check("halt_flag", {15'd0, halt_IFID}, 16'd1);
    check("halt_instr", instr_IFID, 16'h0000);
    check("halt_pc", PC_IFID, 16'h000A);
    check("halt_rd", {15'd0, imem_rd}, 16'd0);
    tick();
    check("halt_hold", {15'd0, halt_IFID}, 16'd1);
    check("halt_rd2", {15'd0, imem_rd}, 16'd0);
    takeBranch_EXMEM = 1'b1; branchTarget = 16'h0010;
    tick();
    takeBranch_EXMEM = 1'b0;
    check("unhalt_flag", {15'd0, halt_IFID}, 16'd0);
    check("unhalt_addr", imem_addr, 16'h0010);
    check("unhalt_rd", {15'd0, imem_rd}, 16'd1);
    tick();
    check("unhalt_instr", instr_IFID, 16'h8010);
    check("unhalt_pc", PC_IFID, 16'h0010);

    // Odd redirect target
    jumpFlush = 1'b1; jumpTarget = 16'h0011;
    tick();
    jumpFlush = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check("align_err", {15'd0, err}, 16'd1);
    check("align_halt", {15'd0, halt_IFID}, 16'd1);
    check("align_nop", instr_IFID, 16'h0800);
    check("align_rd", {15'd0, imem_rd}, 16'd0);
`else
    check("align_err", {15'd0, err}, 16'd0);
    check("align_addr", imem_addr, 16'h0010);
    tick();
    check("align_instr", instr_IFID, 16'h8010);
    check("align_pc", PC_IFID, 16'h0010);
`endif

    // PC+2 wraps at the top of the address space
    jumpFlush = 1'b1; jumpTarget = 16'hFFFE;
    tick();
    jumpFlush = 1'b0;
    tick();
    check("wrap_instr", instr_IFID, 16'hFFFE);
    check("wrap_pc", PC_IFID, 16'hFFFE);
    check("wrap_pc2", PC2_IFID, 16'h0000);
    check("wrap_addr", imem_addr, 16'h0000);

    // Redirect during an outstanding slow request: the old response is dropped
    wait_addr = 16'h0000; wait_n = 4'd3;
    do_reset();
    takeBranch_EXMEM = 1'b1; branchTarget = 16'h0020;
    tick();
    takeBranch_EXMEM = 1'b0;
    check("squash_addr_held", imem_addr, 16'h0000);
    check("squash_nop0", instr_IFID, 16'h0800);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("squash_nop", instr_IFID, 16'h0800);
    end
    check("squash_new_addr", imem_addr, 16'h0020);
    tick();
    check("squash_instr", instr_IFID, 16'h8020);
    check("squash_pc", PC_IFID, 16'h0020);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
